hilo_dispatch: RTL and testbench
================================

# hilo_dispatch

Issue-side controller for the HI/LO multiply/divide unit, sitting in the E stage between the pipeline and the unit. It decides each cycle whether the E-stage HI/LO operation goes to the unit now, is parked in a one-entry pending buffer, or stalls the pipeline. It also drops or keeps parked operations correctly when an exception/interrupt request flushes the pipeline.

## Interface
Parameters:
- MULT_LAT, 5, busy cycles the unit spends on mult/multu (used only with MD_SHADOW_BUSY_EN)
- DIV_LAT, 10, busy cycles the unit spends on div/divu (used only with MD_SHADOW_BUSY_EN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  1  exception/interrupt flush, from the M stage
- e_type  in  4  E-stage op: 0 NONE, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 are treated as NONE
- e_rs  in  32  operand A
- e_rt  in  32  operand B
- md_busy  in  1  unit's registered busy flag; must not include the same-cycle start term
- e_stall  out  1  hold the E-stage instruction and freeze the stages upstream
- md_type  out  4  op code driven to the unit
- md_rs  out  32  operand A to the unit
- md_rt  out  32  operand B to the unit

## Operation
- Op classes:
  - W-ops (1–4, 7, 8) change HI/LO.
  - R-ops (5, 6) read HI/LO combinationally through the unit.
- Pending buffer: one entry holding {type, rs, rt, age}. age = 0 in the cycle after capture; it saturates to 1 after a further cycle.
- unit_busy = md_busy, or the shadow counter when it is compiled in.
- States: EMPTY, HELD.
- EMPTY:
  - W-op and !unit_busy and !req: issue directly (md_* = e_*). No stall.
  - W-op and unit_busy and !req: capture into the buffer, go to HELD. No stall.
  - R-op and !unit_busy: drive md_type = e_type for the read. No stall.
  - R-op and unit_busy: e_stall = 1.
- HELD:
  - !unit_busy and !req: issue the buffer entry, go to EMPTY.
  - Any HI/LO op in E this cycle: e_stall = 1, including the cycle the buffer issues. This preserves order.
- req = 1:
  - md_type = NONE.
  - The E-stage op is not captured or issued.
  - A buffered entry with age 0 (its instruction is now in M) is dropped and the state goes to EMPTY.
  - A buffered entry with age 1 is kept and issues after req deasserts.
- When md_type = NONE, md_rs and md_rt = 0.
- Reset: state EMPTY, buffer cleared, counter 0, e_stall = 0, md_type = 0, md_rs = md_rt = 0.

## Timing
- md_type, md_rs and md_rt are combinational from the state, buffer, e_* and req. e_stall is combinational.
- Direct issue: zero added latency; the op reaches the unit in the same cycle it is in E.
- Buffered issue: issues in the first cycle with !unit_busy and !req.
- The unit's busy rises the cycle after a start. A W-op in the next cycle therefore sees md_busy = 1 and is buffered.
- mthi/mtlo do not set busy. An R-op in the following cycle reads the new value with no stall.
- Simultaneous cases:
  - Buffer draining while a W-op sits in E: E stalls 1 cycle, then is handled from EMPTY.
  - req with a full buffer at age 0: the entry is dropped in that cycle.
  - reset overrides req and everything else.

## Configuration
- MD_SHADOW_BUSY_EN defined:
  - An internal counter is loaded with MULT_LAT (ops 1–2) or DIV_LAT (ops 3–4) on each issue.
  - It decrements each cycle req = 0 and holds while req = 1.
  - unit_busy = (counter != 0). md_busy is ignored.
- MD_SHADOW_BUSY_EN undefined: no counter; unit_busy = md_busy.

## Test plan
- mult in E (rs=3, rt=5), idle unit -> md_type=1 same cycle; e_stall=0.
- mult, then mflo next cycle -> e_stall=1 for 5 cycles (MULT_LAT); md_type=6 in the cycle busy drops.
- div issued, then mthi (rs=0x1234) while busy -> captured, no stall.
  - Next op mfhi stalls until the buffer issues mthi.
  - mfhi then issues in the cycle after.
- mthi buffered, req asserted the next cycle (age 0) -> entry dropped, md_type stays 0.
  - Repeat with req two cycles later -> mthi issues after req falls.
- reset asserted while HELD with the counter at 7 -> next cycle state EMPTY, all outputs 0; a following mult issues immediately.

Source files
------------

// File: rtl/hilo_dispatch_if.sv
// E-stage to HI/LO unit bundle: pipeline-side op and flush in, unit-facing op and stall out.
// master is the pipeline/unit environment, slave is the dispatch controller.
interface hilo_dispatch_if;
   logic        req;
   logic [3:0]  e_type;
   logic [31:0] e_rs;
   logic [31:0] e_rt;
   logic        md_busy;
   logic        e_stall;
   logic [3:0]  md_type;
   logic [31:0] md_rs;
   logic [31:0] md_rt;

   modport master (
      output req, e_type, e_rs, e_rt, md_busy,
      input  e_stall, md_type, md_rs, md_rt
   );

   modport slave (
      input  req, e_type, e_rs, e_rt, md_busy,
      output e_stall, md_type, md_rs, md_rt
   );
endinterface

// File: rtl/hilo_dispatch.sv
// HI/LO issue control with a one-entry pending buffer; direct issue is zero-latency, buffered issue waits for an idle unit.
// Backpressure is e_stall to the pipeline; `define MD_SHADOW_BUSY_EN replaces md_busy with an internal busy counter.
module hilo_dispatch #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic          clk,
   input  logic          reset,
   hilo_dispatch_if.slave bus
);

   typedef enum logic {EMPTY, HELD} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  buf_type;
   logic [31:0] buf_rs;
   logic [31:0] buf_rt;
   logic        buf_age;

   logic        is_w;
   logic        is_r;
   logic        unit_busy;
   logic        capture;
   logic        drain;
   logic        drop;

   if (MULT_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
      $error("hilo_dispatch: latencies must be at least 1");
   end

   always_comb begin
      is_w = 1'b0;
      is_r = 1'b0;
      case (bus.e_type)
         4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8: is_w = 1'b1;
         4'd5, 4'd6:                         is_r = 1'b1;
         default: ;
      endcase
   end

`ifdef MD_SHADOW_BUSY_EN
   localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(LAT_MAX + 1);

   logic [CW-1:0] shadow_cnt;
   logic          unused_md_busy;

   assign unused_md_busy = bus.md_busy;

   // Reload keys off what actually reached the unit, so direct and buffered issues both count.
   always_ff @(posedge clk) begin
      if (reset)
         shadow_cnt <= '0;
      else if (bus.md_type == 4'd1 || bus.md_type == 4'd2)
         shadow_cnt <= CW'(MULT_LAT);
      else if (bus.md_type == 4'd3 || bus.md_type == 4'd4)
         shadow_cnt <= CW'(DIV_LAT);
      else if (!bus.req && shadow_cnt != '0)
         shadow_cnt <= shadow_cnt - CW'(1);
   end

   assign unit_busy = (shadow_cnt != '0);
`else
   assign unit_busy = bus.md_busy;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      drain     = 1'b0;
      drop      = 1'b0;
      case (state)
         EMPTY: begin
            if (is_w && unit_busy && !bus.req) begin
               capture   = 1'b1;
               state_nxt = HELD;
            end
         end
         HELD: begin
            // An age-0 entry's instruction is the one now in M being flushed.
            if (bus.req) begin
               if (!buf_age) begin
                  drop      = 1'b1;
                  state_nxt = EMPTY;
               end
            end else if (!unit_busy) begin
               drain     = 1'b1;
               state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || drain || drop) begin
         buf_type <= '0;
         buf_rs   <= '0;
         buf_rt   <= '0;
         buf_age  <= 1'b0;
      end else if (capture) begin
         buf_type <= bus.e_type;
         buf_rs   <= bus.e_rs;
         buf_rt   <= bus.e_rt;
         buf_age  <= 1'b0;
      end else if (state == HELD) begin
         buf_age  <= 1'b1;
      end
   end

   always_comb begin
      bus.e_stall = 1'b0;
      bus.md_type = 4'd0;
      bus.md_rs   = '0;
      bus.md_rt   = '0;
      if (!reset) begin
         case (state)
            EMPTY: begin
               bus.e_stall = is_r && unit_busy;
               if (!bus.req && !unit_busy && (is_w || is_r)) begin
                  bus.md_type = bus.e_type;
                  bus.md_rs   = bus.e_rs;
                  bus.md_rt   = bus.e_rt;
               end
            end
            HELD: begin
               // Younger HI/LO ops wait behind the buffer, even in the cycle it drains.
               bus.e_stall = is_w || is_r;
               if (drain) begin
                  bus.md_type = buf_type;
                  bus.md_rs   = buf_rs;
                  bus.md_rt   = buf_rt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_dispatch.sv
// Directed bench for hilo_dispatch with a small multiply/divide unit model producing md_busy.
module tb_hilo_dispatch;

   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;
   int   unit_cnt;

   hilo_dispatch_if bus ();

   hilo_dispatch #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unit model: registered busy, high for LAT cycles after the start cycle.
   always @(posedge clk) begin
      if (reset)
         unit_cnt <= 0;
      else if (bus.md_type == 4'd1 || bus.md_type == 4'd2)
         unit_cnt <= 5;
      else if (bus.md_type == 4'd3 || bus.md_type == 4'd4)
         unit_cnt <= 10;
      else if (unit_cnt != 0)
         unit_cnt <= unit_cnt - 1;
   end

   assign bus.md_busy = (unit_cnt != 0);

   task automatic step(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                       input logic r, input logic x_stall, input logic [3:0] x_type,
                       input logic [31:0] x_rs, input logic [31:0] x_rt, input string tag);
      bus.e_type = t;
      bus.e_rs   = a;
      bus.e_rt   = b;
      bus.req    = r;
      #3;
      n_assert++;
      assert (bus.e_stall === x_stall) else begin
         n_fail++;
         $error("FAIL %s e_stall got %0b want %0b", tag, bus.e_stall, x_stall);
      end
      n_assert++;
      assert (bus.md_type === x_type) else begin
         n_fail++;
         $error("FAIL %s md_type got %0d want %0d", tag, bus.md_type, x_type);
      end
      n_assert++;
      assert (bus.md_rs === x_rs) else begin
         n_fail++;
         $error("FAIL %s md_rs got %h want %h", tag, bus.md_rs, x_rs);
      end
      n_assert++;
      assert (bus.md_rt === x_rt) else begin
         n_fail++;
         $error("FAIL %s md_rt got %h want %h", tag, bus.md_rt, x_rt);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_assert   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      bus.req    = 1'b0;
      bus.e_type = 4'd0;
      bus.e_rs   = '0;
      bus.e_rt   = '0;
      @(posedge clk);
      #1;

      step(4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "reset_state");
      reset = 1'b0;

      // mult direct, then mflo waits out the multiply
      step(4'd1, 3, 5, 0, 0, 4'd1, 3, 5, "mult_direct");
      for (int i = 0; i < 5; i++)
         step(4'd6, 0, 0, 0, 1, 4'd0, 0, 0, "mflo_stall");
      step(4'd6, 0, 0, 0, 0, 4'd6, 0, 0, "mflo_read");
      step(4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "idle_a");

      // div, mthi parked while busy, mfhi waits behind the buffer
      step(4'd3, 100, 7, 0, 0, 4'd3, 100, 7, "div_direct");
      step(4'd7, 32'h1234, 0, 0, 0, 4'd0, 0, 0, "mthi_capture");
      for (int i = 0; i < 9; i++)
         step(4'd5, 0, 0, 0, 1, 4'd0, 0, 0, "mfhi_stall_held");
      step(4'd5, 0, 0, 0, 1, 4'd7, 32'h1234, 0, "mthi_drain");
      step(4'd5, 0, 0, 0, 0, 4'd5, 0, 0, "mfhi_read");

      // mthi does not set busy
      step(4'd7, 32'h77, 0, 0, 0, 4'd7, 32'h77, 0, "mthi_direct");
      step(4'd5, 0, 0, 0, 0, 4'd5, 0, 0, "mfhi_no_stall");

      // flush blocks a direct issue
      step(4'd1, 9, 9, 1, 0, 4'd0, 0, 0, "req_blocks_issue");
      step(4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "idle_b");

      // flush at age 0 drops the parked entry
      step(4'd1, 2, 2, 0, 0, 4'd1, 2, 2, "mult_b");
      step(4'd7, 32'hABCD, 0, 0, 0, 4'd0, 0, 0, "mthi_capture_b");
      step(4'd0, 0, 0, 1, 0, 4'd0, 0, 0, "req_age0");
      for (int i = 0; i < 5; i++)
         step(4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "dropped_stays_quiet");

      // flush at age 1 keeps the entry
      step(4'd1, 2, 2, 0, 0, 4'd1, 2, 2, "mult_c");
      step(4'd7, 32'h55, 0, 0, 0, 4'd0, 0, 0, "mthi_capture_c");
      step(4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "held_age_up");
      step(4'd0, 0, 0, 1, 0, 4'd0, 0, 0, "req_age1");
      step(4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "held_wait1");
      step(4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "held_wait2");
      step(4'd0, 0, 0, 0, 0, 4'd7, 32'h55, 0, "mthi_after_req");
      step(4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "idle_c");

      // W-op in E while the buffer drains
      step(4'd1, 1, 1, 0, 0, 4'd1, 1, 1, "mult_d");
      step(4'd8, 9, 0, 0, 0, 4'd0, 0, 0, "mtlo_capture");
      for (int i = 0; i < 4; i++)
         step(4'd2, 4, 6, 0, 1, 4'd0, 0, 0, "multu_stall_held");
      step(4'd2, 4, 6, 0, 1, 4'd8, 9, 0, "mtlo_drain_multu_stall");
      step(4'd2, 4, 6, 0, 0, 4'd2, 4, 6, "multu_from_empty");
      for (int i = 0; i < 5; i++)
         step(4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "idle_d");

      // reset while HELD with the unit counter at 7
      step(4'd3, 1, 1, 0, 0, 4'd3, 1, 1, "div_e");
      step(4'd8, 3, 0, 0, 0, 4'd0, 0, 0, "mtlo_capture_e");
      step(4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "held_e1");
      step(4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "held_e2");
      reset = 1'b1;
      step(4'd1, 3, 5, 1, 0, 4'd0, 0, 0, "reset_outputs");
      reset = 1'b0;
      step(4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "empty_after_reset");
      step(4'd1, 3, 5, 0, 0, 4'd1, 3, 5, "mult_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
